// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and feeds the IF/ID
// register through an output slot backed by a one-entry skid slot.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_pause,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst
);

  typedef enum logic [1:0] {StIdle, StReq, StStall, StDrop} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        skid_valid_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_inst_q;

  logic        consume;
  logic [31:0] branch_pc;
  logic [31:0] pc_inc;

  always_comb begin
    consume   = inst_valid & ~PC_pause;
    branch_pc = branch_target & ~32'd3;
    pc_inc    = pc_q + 32'd4;
  end

  // imem_addr is held separately from pc_q so a redirect can move the PC while the
  // stale request is still waiting for its ack in StDrop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      inst_valid   <= 1'b0;
      inst_pc      <= RESET_PC;
      inst         <= NOP_INST;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= RESET_PC;
      skid_inst_q  <= NOP_INST;
    end else if (branch_en) begin
      inst_valid   <= 1'b0;
      inst         <= NOP_INST;
      skid_valid_q <= 1'b0;
      pc_q         <= branch_pc;
      imem_req     <= 1'b1;
      if (!imem_req || imem_ack) begin
        state_q   <= StReq;
        imem_addr <= branch_pc;
      end else begin
        state_q <= StDrop;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q   <= StReq;
          imem_req  <= 1'b1;
          imem_addr <= pc_q;
        end
        StReq: begin
          if (consume) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
          end
          if (imem_ack) begin
            pc_q <= pc_inc;
            if (!inst_valid || consume) begin
              inst_valid <= 1'b1;
              inst_pc    <= imem_addr;
              inst       <= imem_rdata;
              imem_addr  <= pc_inc;
            end else begin
              skid_valid_q <= 1'b1;
              skid_pc_q    <= imem_addr;
              skid_inst_q  <= imem_rdata;
              state_q      <= StStall;
              imem_req     <= 1'b0;
            end
          end
        end
        StStall: begin
          if (consume) begin
            inst_valid   <= skid_valid_q;
            inst_pc      <= skid_pc_q;
            inst         <= skid_inst_q;
            skid_valid_q <= 1'b0;
            state_q      <= StReq;
            imem_req     <= 1'b1;
            imem_addr    <= pc_q;
          end
        end
        StDrop: begin
          if (imem_ack) begin
            state_q   <= StReq;
            imem_addr <= pc_q;
          end
        end
      endcase
    end
  end

endmodule
